// File: rtl/xpb_pkg.sv
// Shared definitions for the xpb reduction sequencer: default widths,
// the sequencer state encoding and a digit-slice helper.
package xpb_pkg;

    localparam int DIGIT_W_DEF  = 5;
    localparam int WIDTH_DEF    = 1024;

    // Upper bounds for the generic digit-slice helper.
    localparam int XPB_MAX_BITS = 2048;
    localparam int XPB_MAX_DW   = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    // Returns digit i (w bits wide) of a packed digit vector, zero-extended.
    function automatic logic [XPB_MAX_DW-1:0] digit_at(
        input logic [XPB_MAX_BITS-1:0] v,
        input int unsigned             i,
        input int unsigned             w
    );
        logic [XPB_MAX_BITS-1:0] s;
        logic [XPB_MAX_DW-1:0]   m;
        s = v >> (i * w);
        m = (XPB_MAX_DW'(1) << w) - XPB_MAX_DW'(1);
        return XPB_MAX_DW'(s) & m;
    endfunction

endpackage

// File: rtl/xpb_lat_pipe.sv
// Valid shift register tracking in-flight table lookups (LAT >= 1).
// Ports: clk, reset (sync, active-high), clear, in_valid -> out_valid, empty_next.
module xpb_lat_pipe #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic in_valid,
    output logic out_valid,
    output logic empty_next
);

    logic [LAT-1:0] sr_q;
    logic [LAT-1:0] sr_d;

    always_comb begin
        sr_d = (sr_q << 1) | LAT'(in_valid);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign out_valid  = sr_q[LAT-1];
    // Empty once this edge retires the last in-flight lookup.
    assign empty_next = ~|sr_d;

endmodule

// File: rtl/xpb_reduce_seq.sv
// Sequencer summing xpb table values selected by the high-part digits.
// Ports: clk, reset (sync, active-high), start/start_ready, digits,
//   lut_sel/lut_idx/lut_req/lut_data (table bank), busy,
//   sum/out_valid/out_ready (result handshake).
// Optional: define XPB_SKIP_ZERO_EN to skip lookups for zero digits.
module xpb_reduce_seq
    import xpb_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int DIGIT_W = DIGIT_W_DEF,
    parameter int NUM_SEG = 8,
    parameter int LUT_LAT = 1,
    parameter int SEL_W   = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1,
    parameter int ACC_W   = WIDTH + $clog2(NUM_SEG) + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       start_ready,
    input  logic [NUM_SEG*DIGIT_W-1:0] digits,
    output logic [SEL_W-1:0]           lut_sel,
    output logic [DIGIT_W-1:0]         lut_idx,
    output logic                       lut_req,
    input  logic [WIDTH-1:0]           lut_data,
    output logic                       busy,
    output logic [ACC_W-1:0]           sum,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int DIG_BITS = NUM_SEG * DIGIT_W;

    state_t                  state_q;
    state_t                  state_d;
    logic [DIG_BITS-1:0]     dig_q;
    logic [DIG_BITS-1:0]     dig_src;
    logic [XPB_MAX_BITS-1:0] dig_ext;
    logic [XPB_MAX_DW-1:0]   idx_full;
    logic [DIGIT_W-1:0]      idx_pick;
    logic [SEL_W-1:0]        pick;
    logic                    have_pick;
    logic                    accept;
    logic                    load;
    logic                    pipe_out;
    logic                    drain_done;
    logic                    req_q;
    logic [SEL_W-1:0]        sel_q;
    logic [DIGIT_W-1:0]      idx_q;
    logic [ACC_W-1:0]        sum_q;

    assign accept = start && (state_q == IDLE);
    // The lookup register is reloaded on acceptance and every ISSUE cycle,
    // so the first lookup is on the pins the cycle after acceptance.
    assign load   = accept || (state_q == ISSUE);

    // In IDLE the first lookup comes straight from the incoming digits.
    assign dig_src  = (state_q == IDLE) ? digits : dig_q;
    assign dig_ext  = XPB_MAX_BITS'(dig_src);
    assign idx_full = digit_at(dig_ext, 32'(pick), 32'(DIGIT_W));
    assign idx_pick = DIGIT_W'(idx_full);

`ifdef XPB_SKIP_ZERO_EN
    logic [NUM_SEG-1:0] rem_q;
    logic [NUM_SEG-1:0] rem_src;
    logic [NUM_SEG-1:0] nz_in;

    always_comb begin
        nz_in = '0;
        for (int i = 0; i < NUM_SEG; i++) begin
            nz_in[i] = |digits[i*DIGIT_W +: DIGIT_W];
        end
    end

    assign rem_src = (state_q == IDLE) ? nz_in : rem_q;

    // Lowest remaining nonzero segment wins.
    always_comb begin
        have_pick = 1'b0;
        pick      = '0;
        for (int i = NUM_SEG - 1; i >= 0; i--) begin
            if (rem_src[i]) begin
                have_pick = 1'b1;
                pick      = SEL_W'(i);
            end
        end
    end
`else
    logic [SEL_W:0] seg_q;
    logic [SEL_W:0] seg_src;

    assign seg_src   = (state_q == IDLE) ? '0 : seg_q;
    assign have_pick = seg_src < (SEL_W+1)'(NUM_SEG);
    assign pick      = seg_src[SEL_W-1:0];
`endif

    generate
        if (LUT_LAT > 0) begin : g_pipe
            xpb_lat_pipe #(
                .LAT(LUT_LAT)
            ) u_pipe (
                .clk       (clk),
                .reset     (reset),
                .clear     (accept),
                .in_valid  (req_q),
                .out_valid (pipe_out),
                .empty_next(drain_done)
            );
        end else begin : g_nopipe
            assign pipe_out   = req_q;
            assign drain_done = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            dig_q   <= '0;
            req_q   <= 1'b0;
            sel_q   <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
`ifdef XPB_SKIP_ZERO_EN
            rem_q   <= '0;
`else
            seg_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                dig_q <= digits;
            end
            if (load) begin
                if (have_pick) begin
                    req_q <= 1'b1;
                    sel_q <= pick;
                    idx_q <= idx_pick;
`ifdef XPB_SKIP_ZERO_EN
                    rem_q <= rem_src & ~(NUM_SEG'(1) << pick);
`else
                    seg_q <= seg_src + (SEL_W+1)'(1);
`endif
                end else begin
                    req_q <= 1'b0;
                end
            end
            if (accept) begin
                sum_q <= '0;
            end else if (pipe_out) begin
                sum_q <= sum_q + ACC_W'(lut_data);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        start_ready = 1'b0;
        busy        = 1'b1;
        out_valid   = 1'b0;
        unique case (state_q)
            IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
                if (start) begin
                    state_d = have_pick ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                if (!have_pick) begin
                    state_d = (LUT_LAT == 0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign lut_req = req_q;
    assign lut_sel = sel_q;
    assign lut_idx = idx_q;
    assign sum     = sum_q;

endmodule

// File: tb/tb_xpb_reduce_seq.sv
// Self-checking bench for xpb_reduce_seq across several NUM_SEG/LUT_LAT builds.
// Every build sees the same stimulus; a table model answers each lookup.
module tb_xpb_reduce_seq;

    localparam int W    = 32;
    localparam int NCFG = 8;

`ifdef XPB_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    function automatic int cfg_seg(input int g);
        return (g >= 5) ? 1 : 8;
    endfunction

    function automatic int cfg_lat(input int g);
        case (g)
            0: return 1;
            1: return 3;
            2: return 0;
            3: return 2;
            4: return 4;
            5: return 0;
            6: return 2;
            default: return 4;
        endcase
    endfunction

    // Table contents: (segment << 8) | index, with index 0 mapping to 0.
    function automatic logic [W-1:0] lut_f(input int s, input int i);
        if (i == 0) return '0;
        return W'((s << 8) | i);
    endfunction

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic out_ready;
    logic [39:0] digits;

    logic [NCFG-1:0]       o_sr;
    logic [NCFG-1:0]       o_busy;
    logic [NCFG-1:0]       o_req;
    logic [NCFG-1:0]       o_valid;
    logic [NCFG-1:0][2:0]  o_sel;
    logic [NCFG-1:0][4:0]  o_idx;
    logic [NCFG-1:0][39:0] o_sum;

    int n_tests = 0;
    int n_fail  = 0;

    int          first_v [NCFG];
    int          req_cnt [NCFG];
    int          exp_cyc [NCFG];
    int          exp_req [NCFG];
    logic [39:0] exp_sum [NCFG];
    logic [39:0] last_sum[NCFG];
    int          first_req0;
    int          last_req0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NCFG; g++) begin : g_dut
            localparam int NS  = cfg_seg(g);
            localparam int LAT = cfg_lat(g);
            localparam int SW  = (NS > 1) ? $clog2(NS) : 1;
            localparam int AW  = W + $clog2(NS) + 1;

            logic [SW-1:0] sel;
            logic [4:0]    idx;
            logic          req;
            logic [W-1:0]  data;
            logic [AW-1:0] sum;
            logic          srdy;
            logic          bsy;
            logic          ov;
            logic [W-1:0]  junk;

            xpb_reduce_seq #(
                .WIDTH  (W),
                .DIGIT_W(5),
                .NUM_SEG(NS),
                .LUT_LAT(LAT)
            ) u_dut (
                .clk        (clk),
                .reset      (reset),
                .start      (start),
                .start_ready(srdy),
                .digits     (digits[NS*5-1:0]),
                .lut_sel    (sel),
                .lut_idx    (idx),
                .lut_req    (req),
                .lut_data   (data),
                .busy       (bsy),
                .sum        (sum),
                .out_valid  (ov),
                .out_ready  (out_ready)
            );

            // Garbage on the data bus whenever no lookup is due.
            always @(posedge clk) junk <= W'($urandom);

            if (LAT == 0) begin : g_l0
                assign data = req ? lut_f(int'(sel), int'(idx)) : junk;
            end else begin : g_ln
                logic [LAT-1:0]        vq;
                logic [LAT-1:0][W-1:0] dq;
                always @(posedge clk) begin
                    for (int k = LAT - 1; k > 0; k--) begin
                        vq[k] <= vq[k-1];
                        dq[k] <= dq[k-1];
                    end
                    vq[0] <= req;
                    dq[0] <= lut_f(int'(sel), int'(idx));
                end
                assign data = vq[LAT-1] ? dq[LAT-1] : junk;
            end

            assign o_sr[g]    = srdy;
            assign o_busy[g]  = bsy;
            assign o_req[g]   = req;
            assign o_valid[g] = ov;
            assign o_sel[g]   = 3'(sel);
            assign o_idx[g]   = idx;
            assign o_sum[g]   = 40'(sum);
        end
    endgenerate

    task automatic model(input logic [39:0] d);
        for (int g = 0; g < NCFG; g++) begin
            int          k;
            logic [39:0] s;
            k = 0;
            s = '0;
            for (int i = 0; i < cfg_seg(g); i++) begin
                int dg;
                dg = int'(d[i*5 +: 5]);
                if (dg != 0) k++;
                s = s + 40'(lut_f(i, dg));
            end
            exp_req[g] = SKIP ? k : cfg_seg(g);
            exp_sum[g] = s;
            exp_cyc[g] = (exp_req[g] == 0) ? 1 : exp_req[g] + cfg_lat(g) + 1;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        n_tests++;
        if (o_sr !== '1 || o_busy !== '0 || o_valid !== '0) begin
            n_fail++;
            $display("FAIL %s ctrl: sr=%b busy=%b valid=%b, need sr=1s busy=0 valid=0",
                     tag, o_sr, o_busy, o_valid);
        end
        n_tests++;
        if (o_req !== '0 || o_sel !== '0 || o_idx !== '0) begin
            n_fail++;
            $display("FAIL %s lut: req=%b sel=%h idx=%h, need all 0",
                     tag, o_req, o_sel, o_idx);
        end
        n_tests++;
        if (o_sum !== '0) begin
            n_fail++;
            $display("FAIL %s sum: got %h, need 0", tag, o_sum);
        end
    endtask

    task automatic run_op(input logic [39:0] d, input int hold, input bit poke);
        int exp_q[$];
        int got_q[$];
        bit seq_bad;
        model(d);
        for (int i = 0; i < 8; i++) begin
            int dg;
            dg = int'(d[i*5 +: 5]);
            if (!SKIP || dg != 0) exp_q.push_back(i * 32 + dg);
        end
        digits = d;
        start  = 1'b1;
        @(posedge clk);
        for (int g = 0; g < NCFG; g++) begin
            first_v[g] = -1;
            req_cnt[g] = 0;
        end
        first_req0 = -1;
        last_req0  = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (poke && c == 3) begin
                start  = 1'b1;
                digits = ~d;
            end
            if (poke && c == 4) begin
                start  = 1'b0;
                digits = d;
            end
            for (int g = 0; g < NCFG; g++) begin
                if (o_req[g]) req_cnt[g]++;
                if (o_valid[g] && first_v[g] < 0) first_v[g] = c;
            end
            if (o_req[0]) begin
                got_q.push_back(int'(o_sel[0]) * 32 + int'(o_idx[0]));
                if (first_req0 < 0) first_req0 = c;
                last_req0 = c;
            end
            if (&o_valid) break;
        end
        start  = 1'b0;
        digits = d;
        for (int g = 0; g < NCFG; g++) begin
            last_sum[g] = o_sum[g];
            n_tests++;
            if (first_v[g] != exp_cyc[g]) begin
                n_fail++;
                $display("FAIL latency cfg%0d: out_valid at cycle %0d, need %0d",
                         g, first_v[g], exp_cyc[g]);
            end
            n_tests++;
            if (o_sum[g] !== exp_sum[g]) begin
                n_fail++;
                $display("FAIL sum cfg%0d d=%h: got %h, need %h",
                         g, d, o_sum[g], exp_sum[g]);
            end
            n_tests++;
            if (req_cnt[g] != exp_req[g]) begin
                n_fail++;
                $display("FAIL reqcount cfg%0d: got %0d, need %0d",
                         g, req_cnt[g], exp_req[g]);
            end
        end
        seq_bad = (got_q.size() != exp_q.size());
        if (!seq_bad) begin
            foreach (exp_q[i]) if (got_q[i] != exp_q[i]) seq_bad = 1'b1;
        end
        n_tests++;
        if (seq_bad) begin
            n_fail++;
            $display("FAIL issue order d=%h: got %p, need %p", d, got_q, exp_q);
        end
        if (exp_req[0] > 0) begin
            n_tests++;
            if (first_req0 != 1 || last_req0 != exp_req[0]) begin
                n_fail++;
                $display("FAIL req window: cycles %0d..%0d, need 1..%0d",
                         first_req0, last_req0, exp_req[0]);
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (h == 1) begin
                start  = 1'b1;
                digits = 40'({$urandom, $urandom});
            end
            if (h == 2) begin
                start  = 1'b0;
                digits = d;
            end
            n_tests++;
            if (o_valid !== '1 || o_sr !== '0 || o_sum[0] !== exp_sum[0]) begin
                n_fail++;
                $display("FAIL hold h=%0d: valid=%b sr=%b sum=%h, need valid=1s sr=0 sum=%h",
                         h, o_valid, o_sr, o_sum[0], exp_sum[0]);
            end
        end
        start     = 1'b0;
        digits    = d;
        out_ready = 1'b1;
        n_tests++;
        if (o_sr !== '0) begin
            n_fail++;
            $display("FAIL handshake sr: got %b, need 0", o_sr);
        end
        @(negedge clk);
        out_ready = 1'b0;
        n_tests++;
        if (o_valid !== '0 || o_sr !== '1 || o_busy !== '0) begin
            n_fail++;
            $display("FAIL release: valid=%b sr=%b busy=%b, need 0/1s/0",
                     o_valid, o_sr, o_busy);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        digits    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
    endtask

    task automatic test_all_ones();
        logic [39:0] d;
        for (int i = 0; i < 8; i++) d[i*5 +: 5] = 5'd1;
        run_op(d, 0, 1'b0);
        n_tests++;
        if (last_sum[0] !== 40'h1C08 || first_v[0] != 10 || req_cnt[0] != 8) begin
            n_fail++;
            $display("FAIL all_ones: sum=%h cyc=%0d reqs=%0d, need 1c08/10/8",
                     last_sum[0], first_v[0], req_cnt[0]);
        end
    endtask

    task automatic test_all_zero();
        run_op('0, 1, 1'b0);
        n_tests++;
        if (last_sum[0] !== '0 || first_v[0] != (SKIP ? 1 : 10) ||
            req_cnt[0] != (SKIP ? 0 : 8)) begin
            n_fail++;
            $display("FAIL all_zero: sum=%h cyc=%0d reqs=%0d", last_sum[0],
                     first_v[0], req_cnt[0]);
        end
    endtask

    task automatic test_single_digit();
        logic [39:0] d;
        d          = '0;
        d[15 +: 5] = 5'd5;
        run_op(d, 0, 1'b1);
        n_tests++;
        if (last_sum[0] !== 40'h305 || first_v[0] != (SKIP ? 3 : 10) ||
            req_cnt[0] != (SKIP ? 1 : 8)) begin
            n_fail++;
            $display("FAIL single_digit: sum=%h cyc=%0d reqs=%0d", last_sum[0],
                     first_v[0], req_cnt[0]);
        end
    endtask

    task automatic test_backpressure();
        run_op(40'({$urandom, $urandom}), 5, 1'b1);
    endtask

    task automatic test_reset_abort();
        logic [39:0] d;
        d      = 40'({$urandom, $urandom});
        digits = d;
        start  = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("abort");
        reset = 1'b0;
        for (int i = 0; i < 8; i++) d[i*5 +: 5] = 5'h1F;
        run_op(d, 0, 1'b0);
        n_tests++;
        if (last_sum[1] !== 40'h1CF8) begin
            n_fail++;
            $display("FAIL abort leak: sum=%h, need 1cf8", last_sum[1]);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 15; n++) begin
            logic [39:0] d;
            for (int i = 0; i < 8; i++) begin
                d[i*5 +: 5] = ($urandom_range(0, 2) == 0) ? 5'd0 :
                              5'($urandom_range(1, 31));
            end
            run_op(d, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_all_zero();
        test_single_digit();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
